// File: rtl/alu_pkg.sv
// Shared ALU encodings, multiplier FSM states and request payload.
// Optional ALU sharing with the main datapath is enabled by MUL_ALU_SHARE_EN.
package alu_pkg;
   localparam int unsigned XLEN      = 32;
   localparam int unsigned SEL_W     = 3;
   localparam int unsigned SHAMT_W   = 5;
   localparam int unsigned MUL_ITERS = 32;
   localparam int unsigned ITER_W    = $clog2(MUL_ITERS);

   localparam logic [SEL_W-1:0] ALU_ADD  = 3'd0;
   localparam logic [SEL_W-1:0] ALU_SUB  = 3'd1;
   localparam logic [SEL_W-1:0] ALU_SLL  = 3'd2;
   localparam logic [SEL_W-1:0] ALU_SRL  = 3'd3;
   localparam logic [SEL_W-1:0] ALU_AND  = 3'd4;
   localparam logic [SEL_W-1:0] ALU_OR   = 3'd5;
   localparam logic [SEL_W-1:0] ALU_SLT  = 3'd6;
   localparam logic [SEL_W-1:0] ALU_SLTU = 3'd7;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADD  = 3'd1,
      SHL  = 3'd2,
      SHR  = 3'd3,
      DONE = 3'd4
   } mul_state_t;

   typedef struct packed {
      logic [SEL_W-1:0]   sel;
      logic [XLEN-1:0]    in1;
      logic [XLEN-1:0]    in2;
      logic [SHAMT_W-1:0] shamt;
   } alu_req_t;
endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit execute-stage ALU shared with the multiplier.
module alu
   import alu_pkg::*;
(
   input  logic [SEL_W-1:0]   sel_i,
   input  logic [XLEN-1:0]    in1_i,
   input  logic [XLEN-1:0]    in2_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic [XLEN-1:0]    out_o,
   output logic               zero_o
);
   always_comb begin
      out_o = '0;
      case (sel_i)
         ALU_ADD:  out_o = in1_i + in2_i;
         ALU_SUB:  out_o = in1_i - in2_i;
         ALU_SLL:  out_o = in1_i << shamt_i;
         ALU_SRL:  out_o = in1_i >> shamt_i;
         ALU_AND:  out_o = in1_i & in2_i;
         ALU_OR:   out_o = in1_i | in2_i;
         ALU_SLT:  out_o = XLEN'($signed(in1_i) < $signed(in2_i));
         ALU_SLTU: out_o = XLEN'(in1_i < in2_i);
         default:  out_o = '0;
      endcase
   end

   assign zero_o = (out_o == '0);
endmodule

// File: rtl/alu_mux_share.sv
// 2:1 ALU request mux: the sequencer owns the ALU while busy, else the datapath.
module alu_mux_share
   import alu_pkg::*;
(
   input  logic     own_i,
   input  alu_req_t seq_i,
   input  alu_req_t dp_i,
   output alu_req_t alu_o
);
   assign alu_o = own_i ? seq_i : dp_i;
endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier (low 32 bits) sequencing the shared ALU via ADD/SLL/SRL.
// Defining MUL_ALU_SHARE_EN lets the main datapath use the ALU while idle.
module alu_mul_sequencer
   import alu_pkg::*;
#(
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [XLEN-1:0]    op_a,
   input  logic [XLEN-1:0]    op_b,
`ifdef MUL_ALU_SHARE_EN
   input  logic [SEL_W-1:0]   dp_sel,
   input  logic [XLEN-1:0]    dp_in1,
   input  logic [XLEN-1:0]    dp_in2,
   input  logic [SHAMT_W-1:0] dp_shamt,
   output logic               dp_stall,
`endif
   output logic               busy,
   output logic               done,
   output logic [XLEN-1:0]    result,
   output logic [SEL_W-1:0]   alu_sel,
   output logic [XLEN-1:0]    alu_in1,
   output logic [XLEN-1:0]    alu_in2,
   output logic [SHAMT_W-1:0] alu_shamt,
   input  logic [XLEN-1:0]    alu_out
);
   mul_state_t        state_q;
   logic [XLEN-1:0]   mcand_q;
   logic [XLEN-1:0]   mplier_q;
   logic [XLEN-1:0]   product_q;
   logic [ITER_W-1:0] iter_q;
   logic              shr_exit;
   alu_req_t          seq_req;
   alu_req_t          alu_req;

   // ALU request decoded from the current state
   always_comb begin
      seq_req = '0;
      case (state_q)
         ADD: begin
            seq_req.sel = ALU_ADD;
            seq_req.in1 = product_q;
            seq_req.in2 = mcand_q;
         end
         SHL: begin
            seq_req.sel   = ALU_SLL;
            seq_req.in1   = mcand_q;
            seq_req.shamt = SHAMT_W'(1);
         end
         SHR: begin
            seq_req.sel   = ALU_SRL;
            seq_req.in1   = mplier_q;
            seq_req.shamt = SHAMT_W'(1);
         end
         default: seq_req = '0;
      endcase
   end

   assign shr_exit = (EARLY_EXIT && (alu_out == '0)) ||
                     (iter_q == ITER_W'(MUL_ITERS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         product_q <= '0;
         iter_q    <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  mcand_q   <= op_a;
                  mplier_q  <= op_b;
                  product_q <= '0;
                  iter_q    <= '0;
                  if (EARLY_EXIT && (op_b == '0)) begin
                     state_q <= DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     result  <= '0;
                  end else begin
                     state_q <= op_b[0] ? ADD : SHL;
                     busy    <= 1'b1;
                  end
               end else begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
               end
            end
            ADD: begin
               product_q <= alu_out;
               state_q   <= SHL;
            end
            SHL: begin
               mcand_q <= alu_out;
               state_q <= SHR;
            end
            SHR: begin
               mplier_q <= alu_out;
               iter_q   <= iter_q + ITER_W'(1);
               // product is final here: ADD never directly precedes DONE
               if (shr_exit) begin
                  state_q <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  result  <= product_q;
               end else begin
                  state_q <= alu_out[0] ? ADD : SHL;
               end
            end
            default: begin
               state_q <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef MUL_ALU_SHARE_EN
   alu_req_t dp_req;

   assign dp_req   = '{sel: dp_sel, in1: dp_in1, in2: dp_in2, shamt: dp_shamt};
   assign dp_stall = busy;

   alu_mux_share u_mux (
      .own_i (busy),
      .seq_i (seq_req),
      .dp_i  (dp_req),
      .alu_o (alu_req)
   );
`else
   assign alu_req = seq_req;
`endif

   assign alu_sel   = alu_req.sel;
   assign alu_in1   = alu_req.in1;
   assign alu_in2   = alu_req.in2;
   assign alu_shamt = alu_req.shamt;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench: one multiplier with early exit, one running full 32 iterations.
module tb_alu_mul_sequencer;
   import alu_pkg::*;

   typedef struct {
      bit          ee;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      int          n;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, start1, start0;
   logic [31:0] op_a, op_b;

   logic        busy1, done1, busy0, done0, z1, z0;
   logic [31:0] result1, result0, alu_in1_1, alu_in2_1, alu_in1_0, alu_in2_0;
   logic [31:0] alu_out1, alu_out0;
   logic [2:0]  alu_sel1, alu_sel0;
   logic [4:0]  alu_shamt1, alu_shamt0;

`ifdef MUL_ALU_SHARE_EN
   logic [2:0]  dp_sel;
   logic [31:0] dp_in1, dp_in2;
   logic [4:0]  dp_shamt;
   logic        dp_stall1, dp_stall0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_mul_sequencer #(.EARLY_EXIT(1'b1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .op_a(op_a), .op_b(op_b),
`ifdef MUL_ALU_SHARE_EN
      .dp_sel(dp_sel), .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_shamt(dp_shamt),
      .dp_stall(dp_stall1),
`endif
      .busy(busy1), .done(done1), .result(result1),
      .alu_sel(alu_sel1), .alu_in1(alu_in1_1), .alu_in2(alu_in2_1),
      .alu_shamt(alu_shamt1), .alu_out(alu_out1)
   );

   alu u_alu1 (
      .sel_i(alu_sel1), .in1_i(alu_in1_1), .in2_i(alu_in2_1),
      .shamt_i(alu_shamt1), .out_o(alu_out1), .zero_o(z1)
   );

   alu_mul_sequencer #(.EARLY_EXIT(1'b0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .op_a(op_a), .op_b(op_b),
`ifdef MUL_ALU_SHARE_EN
      .dp_sel(dp_sel), .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_shamt(dp_shamt),
      .dp_stall(dp_stall0),
`endif
      .busy(busy0), .done(done0), .result(result0),
      .alu_sel(alu_sel0), .alu_in1(alu_in1_0), .alu_in2(alu_in2_0),
      .alu_shamt(alu_shamt0), .alu_out(alu_out0)
   );

   alu u_alu0 (
      .sel_i(alu_sel0), .in1_i(alu_in1_0), .in2_i(alu_in2_0),
      .shamt_i(alu_shamt0), .out_o(alu_out0), .zero_o(z0)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Pulse start, count edges (sampling edge = 1) until done, then check.
   task automatic run_mul(input bit ee, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int exp_n, input string nm);
      int   n;
      logic d;
      @(negedge clk);
      op_a = a;
      op_b = b;
      if (ee) start1 = 1'b1; else start0 = 1'b1;
      n = 0;
      d = 1'b0;
      while (!d && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) begin
            start1 = 1'b0;
            start0 = 1'b0;
            chk({nm, "_busy_first"}, 32'(ee ? busy1 : busy0), 32'(exp_n > 1));
         end
         d = ee ? done1 : done0;
      end
      chk({nm, "_edges"}, 32'(n), 32'(exp_n));
      chk({nm, "_result"}, ee ? result1 : result0, exp_r);
      chk({nm, "_busy_in_done"}, 32'(ee ? busy1 : busy0), 32'd0);
   endtask

   vec_t        vecs[10];
   logic [2:0]  exp_sel[8];

   initial begin
      int   n;
      logic d;

      vecs[0] = '{1'b1, 32'd3,          32'd5,          32'd15,         9};
      vecs[1] = '{1'b1, 32'd7,          32'd0,          32'd0,          1};
      vecs[2] = '{1'b1, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE,   6};
      vecs[3] = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   97};
      vecs[4] = '{1'b0, 32'd3,          32'd5,          32'd15,         67};
      vecs[5] = '{1'b1, 32'h12345678,   32'h10,         32'h23456780,   12};
      vecs[6] = '{1'b1, 32'h80000000,   32'd3,          32'h80000000,   7};
      vecs[7] = '{1'b0, 32'd7,          32'd0,          32'd0,          65};
      vecs[8] = '{1'b1, 32'd100,        32'd100,        32'd10000,      18};
      vecs[9] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   97};
      exp_sel = '{3'd0, 3'd2, 3'd3, 3'd2, 3'd3, 3'd0, 3'd2, 3'd3};

      reset  = 1'b1;
      start1 = 1'b1;
      start0 = 1'b1;
      op_a   = 32'd3;
      op_b   = 32'd5;
`ifdef MUL_ALU_SHARE_EN
      dp_sel = '0; dp_in1 = '0; dp_in2 = '0; dp_shamt = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy1",   32'(busy1), 32'd0);
      chk("rst_done1",   32'(done1), 32'd0);
      chk("rst_result1", result1,    32'd0);
      chk("rst_alu_sel", 32'(alu_sel1), 32'd0);
      chk("rst_alu_in1", alu_in1_1,  32'd0);
      chk("rst_busy0",   32'(busy0), 32'd0);
      chk("rst_result0", result0,    32'd0);
      start1 = 1'b0;
      start0 = 1'b0;
      reset  = 1'b0;

      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 1) @(negedge clk);
         run_mul(vecs[i].ee, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].n, $sformatf("vec%0d", i));
      end

      // done is a single-cycle pulse and result holds afterwards
      @(posedge clk); #1;
      chk("done_pulse", 32'(done1), 32'd0);
      chk("result_hold", result1, 32'd10000);

      // State trace of 3*5 through the ALU select, plus ignored start while busy
      @(negedge clk);
      op_a = 32'd3; op_b = 32'd5; start1 = 1'b1;
      n = 0; d = 1'b0;
      while (!d && n < 200) begin
         @(posedge clk); #1; n++;
         start1 = 1'b0;
         if (n == 2) begin
            op_a = 32'd9; start1 = 1'b1;
         end
         if (n <= 8)
            chk($sformatf("trace%0d", n), {28'd0, busy1, alu_sel1}, {28'd0, 1'b1, exp_sel[n-1]});
         if (n < 8) chk($sformatf("hold%0d", n), result1, 32'd10000);
         d = done1;
      end
      chk("ignore_edges",  32'(n), 32'd9);
      chk("ignore_result", result1, 32'd15);

      // Reset mid-operation aborts immediately
      @(posedge clk); #1;
      @(negedge clk);
      op_a = 32'd3; op_b = 32'd5; start1 = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         start1 = 1'b0;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy",    32'(busy1),    32'd0);
      chk("abort_done",    32'(done1),    32'd0);
      chk("abort_result",  result1,       32'd0);
      chk("abort_alu_sel", 32'(alu_sel1), 32'd0);
      chk("abort_alu_in1", alu_in1_1,     32'd0);
      reset = 1'b0;
      run_mul(1'b1, 32'd3, 32'd5, 32'd15, 9, "after_abort");

`ifdef MUL_ALU_SHARE_EN
      @(negedge clk); @(negedge clk);
      dp_sel = 3'd1; dp_in1 = 32'd10; dp_in2 = 32'd4;
      #1;
      chk("share_idle_out",   alu_out1, 32'd6);
      chk("share_idle_stall", 32'(dp_stall1), 32'd0);
      @(negedge clk);
      op_a = 32'd3; op_b = 32'd5; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      chk("share_busy_stall", 32'(dp_stall1), 32'd1);
      chk("share_busy_sel",   32'(alu_sel1),  32'd0);
      chk("share_busy_in1",   alu_in1_1,      32'd0);
      chk("share_busy_in2",   alu_in2_1,      32'd3);
      n = 1; d = 1'b0;
      while (!d && n < 200) begin
         @(posedge clk); #1; n++;
         d = done1;
      end
      chk("share_edges",  32'(n), 32'd9);
      chk("share_result", result1, 32'd15);
      dp_sel = '0; dp_in1 = '0; dp_in2 = '0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
